mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter for the single-ported unified instruction/data memory of the multi-cycle CPU. It shares one memory port between the CPU memory stage and a DMA/debug loader. Each requester uses a per-transaction req/ack handshake. Grants are registered: one owner per cycle, decided at each clock edge. The CPU holds its FSM state while its request is pending and unacknowledged.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- MAX_WAIT, 4, consecutive CPU grants tolerated while DMA waits (used only with ARB_FAIR_EN)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- cpu_req  in  1  CPU transaction pending; addr/we/wdata stable while high
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  transaction performed this cycle
- cpu_rdata  out  DATA_W  read data, valid when cpu_ack & ~cpu_we
- cpu_stall  out  1  cpu_req & ~cpu_ack
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  same meanings for DMA
- dma_ack, dma_rdata  out  1/DATA_W  same meanings for DMA
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe, sampled by memory at the rising edge
- mem_rdata  in  DATA_W  combinational memory read data
- owner  out  2  00 idle, 01 CPU, 10 DMA (registered state)

## Operation
- States: IDLE (00), CPU (01), DMA (10). 11 is unreachable and decodes as IDLE.
- Next state is computed from the req inputs sampled at every edge, in every state:
  - none pending -> IDLE
  - only one pending -> that requester
  - both pending -> CPU, except DMA when fairness is enabled and wait_cnt == MAX_WAIT
- In owner state X:
  - mem_addr/mem_wdata = X_addr/X_wdata
  - mem_read = ~X_we; mem_write = X_we
  - X_ack = 1 (combinational from state)
  - X_rdata = mem_rdata
- The non-owner's ack is 0 and its rdata is 0.
- In IDLE, all mem_* outputs, both acks and both rdata are 0.
- Handshake:
  - A requester observing ack either drops req at the next edge, or keeps req high and presents its next transaction at that edge.
  - A req still high at the edge ending an ack cycle is a new transaction.
  - Inputs change only at clock edges.
- wait_cnt (width clog2(MAX_WAIT+1)):
  - +1 on each edge that grants CPU while dma_req = 1
  - cleared on a DMA grant or when dma_req = 0
  - saturates at MAX_WAIT

## Timing
- Reset (reset = 0): owner = 00, wait_cnt = 0, all outputs 0, asynchronously; a mem_write in progress is withdrawn in the same cycle.
- First edge with reset = 1 performs normal arbitration.
- Latency: req rising before edge N -> ack high during cycle N to N+1. There is one idle cycle from IDLE.
- Back-to-back: a requester holding req while it is the sole requester gets an ack every cycle (100% port utilisation).
- Contention, strict mode: CPU granted every cycle while cpu_req is held; DMA waits indefinitely.
- Contention, fair mode: after MAX_WAIT consecutive CPU grants with dma_req high, the next edge grants DMA for exactly one cycle, then CPU again (if still requesting).
- A request that drops before being granted is discarded with no ack. This is legal only for DMA; the CPU must hold req until ack.

## Configuration
- ARB_FAIR_EN defined: wait_cnt is implemented and a DMA grant is forced as described.
- ARB_FAIR_EN undefined: no wait_cnt register; strict CPU priority; MAX_WAIT is unused.

## Test plan
- Reset: hold reset = 0 with both reqs high -> owner = 00, mem_read = mem_write = 0, acks 0. Release reset -> first edge gives owner = 01.
- Single CPU read: mem[0x40] = 0x1234ABCD; cpu_req with addr 0x40 before edge N -> cpu_ack and cpu_rdata = 0x1234ABCD in cycle N only; cpu_stall = 1 before N.
- DMA burst: 4 writes to 0x100..0x10C held back-to-back, CPU idle -> 4 consecutive dma_ack cycles, memory holds the 4 words, owner = 10 throughout.
- Contention, ARB_FAIR_EN on, MAX_WAIT = 4: both reqs held -> grant pattern CPU×4, DMA×1, repeating. Macro off -> CPU every cycle, dma_ack never asserted.
- Reset mid-access: reset = 0 during a CPU write cycle, before the edge -> mem_write falls immediately, memory unchanged, owner = 00.
- Dropped DMA request: dma_req pulsed for one cycle while CPU is granted -> no dma_ack; wait_cnt returns to 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port between CPU and DMA/debug loader.
// Define ARB_FAIR_EN to force a DMA grant after MAX_WAIT consecutive CPU grants.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  // state | meaning
  // IDLE  | port unused this cycle
  // CPU   | CPU transaction performed this cycle
  // DMA   | DMA transaction performed this cycle
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CPU  = 2'b01,
    ST_DMA  = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   force_dma;

  always_comb begin
    state_nxt = ST_IDLE;
    if (cpu_req && dma_req)
      state_nxt = force_dma ? ST_DMA : ST_CPU;
    else if (cpu_req)
      state_nxt = ST_CPU;
    else if (dma_req)
      state_nxt = ST_DMA;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

`ifdef ARB_FAIR_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;

  assign force_dma = (wait_cnt == CNT_MAX);

  // Counts CPU grants taken while DMA is waiting; a dropped DMA request forgets its wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      wait_cnt <= '0;
    else if (!dma_req || state_nxt == ST_DMA)
      wait_cnt <= '0;
    else if (state_nxt == ST_CPU && wait_cnt != CNT_MAX)
      wait_cnt <= wait_cnt + CNT_W'(1);
  end
`else
  // Strict CPU priority: the fairness bound never triggers.
  assign force_dma = (MAX_WAIT < 0);
`endif

  // Port steering is decoded from the registered owner, so reset clears it at once.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    cpu_ack   = 1'b0;
    cpu_rdata = '0;
    dma_ack   = 1'b0;
    dma_rdata = '0;
    case (state)
      ST_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_read  = ~cpu_we;
        mem_write = cpu_we;
        cpu_ack   = 1'b1;
        cpu_rdata = mem_rdata;
      end
      ST_DMA: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_read  = ~dma_we;
        mem_write = dma_we;
        dma_ack   = 1'b1;
        dma_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_ack & reset;
  assign owner     = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: cycle table plus contention/reset sequences.
// Contention expectations follow ARB_FAIR_EN when it is defined for the build.
module tb_mem_port_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
  logic              cpu_ack, cpu_stall, dma_ack, mem_read, mem_write;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;
  logic [1:0]        owner;

  logic [31:0] mem [0:255];
  logic        preload;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  // Memory: combinational read, write sampled at the rising edge.
  assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[16] <= 32'h1234ABCD;
      mem[17] <= 32'hCAFEF00D;
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        dr, dw;
    logic [31:0] da, dd;
    logic [1:0]  eo;
    logic [31:0] ecr, edr;
  } vec_t;

  typedef struct {
    logic [1:0]  owner;
    logic        cpu_ack, dma_ack, cpu_stall, mem_read, mem_write;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[14];

  function automatic vec_t mk(input logic cr, input logic cw, input logic [31:0] ca,
                              input logic [31:0] cd, input logic dr, input logic dw,
                              input logic [31:0] da, input logic [31:0] dd,
                              input logic [1:0] eo, input logic [31:0] ecr,
                              input logic [31:0] edr);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.eo = eo; v.ecr = ecr; v.edr = edr;
    return v;
  endfunction

  function automatic exp_t expect_of(input vec_t v, input string tag);
    exp_t e;
    e.owner = v.eo; e.tag = tag;
    e.cpu_ack = 1'b0; e.dma_ack = 1'b0; e.mem_read = 1'b0; e.mem_write = 1'b0;
    e.cpu_rdata = 32'h0; e.dma_rdata = 32'h0; e.mem_addr = 32'h0; e.mem_wdata = 32'h0;
    if (v.eo == 2'b01) begin
      e.cpu_ack = 1'b1; e.cpu_rdata = v.ecr; e.mem_addr = v.ca; e.mem_wdata = v.cd;
      e.mem_read = ~v.cw; e.mem_write = v.cw;
    end else if (v.eo == 2'b10) begin
      e.dma_ack = 1'b1; e.dma_rdata = v.edr; e.mem_addr = v.da; e.mem_wdata = v.dd;
      e.mem_read = ~v.dw; e.mem_write = v.dw;
    end
    e.cpu_stall = v.cr & ~e.cpu_ack;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
    dma_req = v.dr; dma_we = v.dw; dma_addr = v.da; dma_wdata = v.dd;
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty actual=0 expected=1");
      return;
    end
    e = sb_q.pop_front();
    chk({e.tag, " owner"},     owner,     e.owner);
    chk({e.tag, " cpu_ack"},   cpu_ack,   e.cpu_ack);
    chk({e.tag, " dma_ack"},   dma_ack,   e.dma_ack);
    chk({e.tag, " cpu_stall"}, cpu_stall, e.cpu_stall);
    chk({e.tag, " mem_read"},  mem_read,  e.mem_read);
    chk({e.tag, " mem_write"}, mem_write, e.mem_write);
    chk({e.tag, " mem_addr"},  mem_addr,  e.mem_addr);
    chk({e.tag, " mem_wdata"}, mem_wdata, e.mem_wdata);
    chk({e.tag, " cpu_rdata"}, cpu_rdata, e.cpu_rdata);
    chk({e.tag, " dma_rdata"}, dma_rdata, e.dma_rdata);
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic run_cycle(input vec_t v, input string tag);
    drive(v);
    sb_q.push_back(expect_of(v, tag));
    @(negedge clk);
    check_pop();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] contend_owner(input int j);
`ifdef ARB_FAIR_EN
    return ((j % (MAX_WAIT + 1)) == MAX_WAIT) ? 2'b10 : 2'b01;
`else
    return (j < 0) ? 2'b10 : 2'b01;
`endif
  endfunction

  initial begin
    vec_t v;
    logic [1:0] eo;
    logic       dpat [10];
    logic [1:0] mo   [12];

    tbl[0]  = mk(1,0,32'h40,0,           0,0,0,0,                    2'b00, 0, 0);
    tbl[1]  = mk(0,0,32'h40,0,           0,0,0,0,                    2'b01, 32'h1234ABCD, 0);
    tbl[2]  = mk(0,0,0,0,                1,1,32'h100,32'hD0000000,   2'b00, 0, 0);
    tbl[3]  = mk(0,0,0,0,                1,1,32'h100,32'hD0000000,   2'b10, 0, 0);
    tbl[4]  = mk(0,0,0,0,                1,1,32'h104,32'hD0000001,   2'b10, 0, 0);
    tbl[5]  = mk(0,0,0,0,                1,1,32'h108,32'hD0000002,   2'b10, 0, 0);
    tbl[6]  = mk(0,0,0,0,                0,1,32'h10C,32'hD0000003,   2'b10, 0, 0);
    tbl[7]  = mk(1,1,32'h80,32'hAAAA5555,0,0,0,0,                    2'b00, 0, 0);
    tbl[8]  = mk(0,1,32'h80,32'hAAAA5555,0,0,0,0,                    2'b01, 0, 0);
    tbl[9]  = mk(1,0,32'h80,0,           0,0,0,0,                    2'b00, 0, 0);
    tbl[10] = mk(0,0,32'h80,0,           0,0,0,0,                    2'b01, 32'hAAAA5555, 0);
    tbl[11] = mk(0,0,0,0,                1,0,32'h104,0,              2'b00, 0, 0);
    tbl[12] = mk(0,0,0,0,                0,0,32'h104,0,              2'b10, 0, 32'hD0000001);
    tbl[13] = mk(0,0,0,0,                0,0,0,0,                    2'b00, 0, 0);

    // Reset held with both requesters active.
    reset = 1'b0; preload = 1'b1;
    drive(mk(1,0,32'h40,0, 1,0,32'h44,0, 2'b00, 0, 0));
    repeat (2) @(negedge clk);
    chk("rst owner",     owner,     2'b00);
    chk("rst mem_read",  mem_read,  1'b0);
    chk("rst mem_write", mem_write, 1'b0);
    chk("rst cpu_ack",   cpu_ack,   1'b0);
    chk("rst dma_ack",   dma_ack,   1'b0);
    chk("rst mem_addr",  mem_addr,  32'h0);
    @(posedge clk); #1;
    reset = 1'b1; preload = 1'b0;
    run_cycle(mk(1,0,32'h40,0, 1,0,32'h44,0, 2'b00, 0, 0), "rel0");
    run_cycle(mk(0,0,32'h40,0, 0,0,32'h44,0, 2'b01, 32'h1234ABCD, 0), "rel1");

    for (int i = 0; i < 14; i++) run_cycle(tbl[i], $sformatf("row%0d", i));
    chk("burst mem0", mem[64], 32'hD0000000);
    chk("burst mem1", mem[65], 32'hD0000001);
    chk("burst mem2", mem[66], 32'hD0000002);
    chk("burst mem3", mem[67], 32'hD0000003);
    chk("cpu wr mem", mem[32], 32'hAAAA5555);

    // Contention: both held for 12 cycles, then released.
    for (int k = 0; k < 14; k++) begin
      eo = (k == 0 || k == 13) ? 2'b00 : contend_owner(k - 1);
      if (k < 12) v = mk(1,0,32'h40,0, 1,0,32'h44,0, eo, 32'h1234ABCD, 32'hCAFEF00D);
      else        v = mk(0,0,32'h40,0, 0,0,32'h44,0, eo, 32'h1234ABCD, 32'hCAFEF00D);
      run_cycle(v, $sformatf("cont%0d", k));
    end

    // One-cycle DMA pulse under CPU grant, then sustained contention.
    dpat = '{0,1,0,0,1,1,1,1,1,1};
    mo   = '{2'b00,2'b01,2'b01,2'b01,2'b01,2'b01,2'b01,2'b01,2'b01,2'b01,2'b01,2'b00};
`ifdef ARB_FAIR_EN
    mo[9] = 2'b10;
`endif
    for (int m = 0; m < 12; m++) begin
      if (m < 10) v = mk(1,0,32'h40,0, dpat[m],0,32'h44,0, mo[m], 32'h1234ABCD, 32'hCAFEF00D);
      else        v = mk(0,0,32'h40,0, 0,0,32'h44,0,       mo[m], 32'h1234ABCD, 32'hCAFEF00D);
      run_cycle(v, $sformatf("drop%0d", m));
    end

    // Reset asserted in the middle of a CPU write cycle.
    run_cycle(mk(1,1,32'h90,32'h5A5A5A5A, 0,0,0,0, 2'b00, 0, 0), "mid0");
    drive(mk(0,1,32'h90,32'h5A5A5A5A, 0,0,0,0, 2'b00, 0, 0));
    @(negedge clk);
    chk("mid mem_write before", mem_write, 1'b1);
    chk("mid owner before",     owner,     2'b01);
    #1 reset = 1'b0;
    #1;
    chk("mid mem_write after", mem_write, 1'b0);
    chk("mid owner after",     owner,     2'b00);
    chk("mid cpu_ack after",   cpu_ack,   1'b0);
    @(posedge clk); #1;
    chk("mid mem unchanged", mem[36], 32'h0);
    reset = 1'b1;
    run_cycle(mk(0,0,0,0, 0,0,0,0, 2'b00, 0, 0), "mid1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
